seg_display_ctrl: RTL and testbench
===================================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter PRESCALE_W, default 16, width of the digit-dwell prescaler register and counter.
REQ-003 SHALL have port HCLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have AHB-Lite slave inputs HADDR[31:0], HWDATA[31:0], HWRITE, HREADY, HSEL, HSIZE[2:0], HTRANS[1:0]; only HADDR[4:2] decoded.
REQ-006 SHALL have port HRDATA  output  32  read data, valid in data phase.
REQ-007 SHALL have port HREADYOUT  output  1  tied 1, zero wait states.
REQ-008 SHALL have ports SegA..SegG, DP  output  1 each  segment drives, active-high.
REQ-009 SHALL have port nDigit  output  NUM_DIGITS  digit enables, active-low one-hot.

Function
REQ-010 Register map (word offset = HADDR[4:2]): 0 DATA (4*NUM_DIGITS bits, nibble i = digit i), 1 DP_MASK, 2 BLANK_MASK, 3 BLINK_MASK (NUM_DIGITS bits each), 4 PRESCALE (PRESCALE_W bits), 5 BLINK_DIV (8 bits), 6 CTRL (bit0 ENABLE, bit1 LZB leading-zero blank).
REQ-011 Address phase SHALL be captured when HSEL && HREADY && HTRANS[1]; write data SHALL be taken from HWDATA in the following cycle, unused upper bits ignored.
REQ-012 HRDATA SHALL return the addressed register zero-extended in the data phase; offsets 7 and unselected cycles SHALL return 0.
REQ-013 Digit index SHALL advance when the dwell counter reaches max(PRESCALE,1)-1, then counter clears; index wraps NUM_DIGITS-1 -> 0.
REQ-014 A write to PRESCALE SHALL clear the dwell counter in the same cycle the register updates.
REQ-015 A frame = one full index wrap; frame counter SHALL toggle blink phase when it reaches BLINK_DIV-1 and clear; BLINK_DIV=0 SHALL hold blink phase "on".
REQ-016 Digit i SHALL be dark (all segments and DP 0, nDigit still scanned) if BLANK_MASK[i], or BLINK_MASK[i] and blink phase "off", or LZB-blanked.
REQ-017 LZB: with CTRL.LZB=1, digit i SHALL be blanked iff nibble i and all higher nibbles are 0, i>0, and no DP_MASK bit set at index >= i.
REQ-018 Segment decode SHALL cover 0-9 and A,b,C,d,E,F in standard hex glyphs; DP = DP_MASK[index].
REQ-019 Seg*/DP/nDigit SHALL be registered: outputs reflect index and register contents with exactly 1 cycle latency.
REQ-020 CTRL.ENABLE=0 SHALL force nDigit all-ones, Seg*/DP 0, and hold dwell counter, index, frame counter and blink phase at 0.
REQ-021 A register write SHALL be visible on outputs at the next output register update; no tearing within a digit slot beyond 1 cycle.

Reset
REQ-022 HRESET=1 at a rising edge SHALL clear all registers, counters, index, blink phase, pending write; CTRL resets to 0x1 (enabled, LZB off), PRESCALE to 1.
REQ-023 After reset outputs SHALL be nDigit=~1 (digit 0 active), Seg pattern for "0", DP=0; HRDATA=0.
REQ-024 Reset asserted mid-transfer SHALL abort the pending write; no register changes.

Structure
REQ-025 Register offsets, CTRL bit positions and the 7-segment glyph function SHALL live in package seg_display_pkg.
REQ-026 Segment decode SHALL be one combinational sub-module seg7_decode (4-bit in, 7 segments out); scan and AHB logic stay in seg_display_ctrl.

Verification
REQ-027 Reset, then observe 8 cycles with PRESCALE=1 -> nDigit cycles 1110,1101,1011,0111 each cycle, all digits show "0".
REQ-028 Write DATA=0x12AF, PRESCALE=3 -> each digit active 3 cycles; digit0 glyph F, digit3 glyph 1; read DATA returns 0x000012AF.
REQ-029 DATA=0x0005, DP_MASK=0b0010, CTRL=0x3 -> digits 3,2 dark, digit1 "0" with DP, digit0 "5".
REQ-030 BLINK_MASK=0b0001, BLINK_DIV=2, PRESCALE=1 -> digit0 dark on alternate pairs of frames (8-cycle lit, 8-cycle dark); BLINK_DIV=0 -> always lit.
REQ-031 Write PRESCALE=5 mid-dwell, then CTRL=0 -> counter restarts at 0; after disable nDigit=1111, segments 0; re-enable restarts at digit 0.
REQ-032 Assert HRESET in data phase of a DATA write of 0xFFFF -> DATA reads 0 after reset.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared definitions for the multiplexed 7-segment display controller:
// register offsets (word index = HADDR[4:2]), CTRL bit positions, reset
// values and the hex glyph table.
// Glyph bit order is {g,f,e,d,c,b,a}, so bit 0 is segment A.
package seg_display_pkg;

   typedef enum logic [2:0] {
      REG_DATA       = 3'd0,
      REG_DP_MASK    = 3'd1,
      REG_BLANK_MASK = 3'd2,
      REG_BLINK_MASK = 3'd3,
      REG_PRESCALE   = 3'd4,
      REG_BLINK_DIV  = 3'd5,
      REG_CTRL       = 3'd6
   } reg_off_e;

   localparam int         CTRL_ENABLE_BIT = 0;
   localparam int         CTRL_LZB_BIT    = 1;
   localparam logic [1:0] CTRL_RESET      = 2'b01;

   function automatic logic [6:0] seg7_glyph(input logic [3:0] value);
      case (value)
         4'h0:    seg7_glyph = 7'h3F;
         4'h1:    seg7_glyph = 7'h06;
         4'h2:    seg7_glyph = 7'h5B;
         4'h3:    seg7_glyph = 7'h4F;
         4'h4:    seg7_glyph = 7'h66;
         4'h5:    seg7_glyph = 7'h6D;
         4'h6:    seg7_glyph = 7'h7D;
         4'h7:    seg7_glyph = 7'h07;
         4'h8:    seg7_glyph = 7'h7F;
         4'h9:    seg7_glyph = 7'h6F;
         4'hA:    seg7_glyph = 7'h77;
         4'hB:    seg7_glyph = 7'h7C;
         4'hC:    seg7_glyph = 7'h39;
         4'hD:    seg7_glyph = 7'h5E;
         4'hE:    seg7_glyph = 7'h79;
         default: seg7_glyph = 7'h71;
      endcase
   endfunction

endpackage

// File: rtl/seg_display_ctrl_seg7_decode.sv
// Combinational hex to 7-segment decoder.
// Ports: value - 4-bit nibble in; segs - {g,f,e,d,c,b,a}, active-high.
module seg7_decode
   import seg_display_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] segs
);

   assign segs = seg7_glyph(value);

endmodule

// File: rtl/seg_display_ctrl.sv
// AHB-Lite slave driving a NUM_DIGITS multiplexed 7-segment display.
// Ports:
//   HCLK, HRESET              clock, synchronous active-high reset
//   HADDR..HTRANS             AHB-Lite slave inputs (only HADDR[4:2] decoded)
//   HRDATA, HREADYOUT         read data (data phase), always ready
//   SegA..SegG, DP            registered segment drives, active-high
//   nDigit                    registered digit enables, active-low one-hot
module seg_display_ctrl
   import seg_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE_W = 16
)(
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic [31:0]           HADDR,
   input  logic [31:0]           HWDATA,
   input  logic                  HWRITE,
   input  logic                  HREADY,
   input  logic                  HSEL,
   input  logic [2:0]            HSIZE,
   input  logic [1:0]            HTRANS,
   output logic [31:0]           HRDATA,
   output logic                  HREADYOUT,
   output logic                  SegA,
   output logic                  SegB,
   output logic                  SegC,
   output logic                  SegD,
   output logic                  SegE,
   output logic                  SegF,
   output logic                  SegG,
   output logic                  DP,
   output logic [NUM_DIGITS-1:0] nDigit
);

   localparam int DW = 4 * NUM_DIGITS;
   localparam int IW = $clog2(NUM_DIGITS);

   // Registers
   logic [DW-1:0]         data_q;
   logic [NUM_DIGITS-1:0] dp_mask_q, blank_mask_q, blink_mask_q;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [7:0]            blink_div_q;
   logic [1:0]            ctrl_q;

   // Bus pipeline
   logic       addr_ph, wr_pend_q, rd_pend_q, wr_prescale;
   logic [2:0] addr_q;

   // Scan state
   logic [PRESCALE_W-1:0] cnt_q, dwell_last;
   logic [IW-1:0]         idx_q;
   logic                  idx_last, enable;
   logic [7:0]            frame_q;
   logic                  blink_off_q;

   // Digit composition
   logic [NUM_DIGITS-1:0] lzb_blank;
   logic                  lz_run, dark;
   logic [3:0]            nibble;
   logic [6:0]            glyph, seg_q;
   logic                  dp_q;
   logic [NUM_DIGITS-1:0] ndigit_q;

   logic unused_bits;
   assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HSIZE, HTRANS[0], HWDATA};

   assign HREADYOUT = 1'b1;
   assign enable    = ctrl_q[CTRL_ENABLE_BIT];

   // ---------------- AHB address/data phase ----------------
   assign addr_ph     = HSEL && HREADY && HTRANS[1];
   assign wr_prescale = wr_pend_q && (addr_q == REG_PRESCALE);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wr_pend_q <= 1'b0;
         rd_pend_q <= 1'b0;
         addr_q    <= '0;
      end else begin
         wr_pend_q <= addr_ph && HWRITE;
         rd_pend_q <= addr_ph && !HWRITE;
         if (addr_ph) addr_q <= HADDR[4:2];
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         data_q       <= '0;
         dp_mask_q    <= '0;
         blank_mask_q <= '0;
         blink_mask_q <= '0;
         prescale_q   <= PRESCALE_W'(1);
         blink_div_q  <= '0;
         ctrl_q       <= CTRL_RESET;
      end else if (wr_pend_q) begin
         case (addr_q)
            REG_DATA:       data_q       <= HWDATA[DW-1:0];
            REG_DP_MASK:    dp_mask_q    <= HWDATA[NUM_DIGITS-1:0];
            REG_BLANK_MASK: blank_mask_q <= HWDATA[NUM_DIGITS-1:0];
            REG_BLINK_MASK: blink_mask_q <= HWDATA[NUM_DIGITS-1:0];
            REG_PRESCALE:   prescale_q   <= HWDATA[PRESCALE_W-1:0];
            REG_BLINK_DIV:  blink_div_q  <= HWDATA[7:0];
            REG_CTRL:       ctrl_q       <= HWDATA[1:0];
            default: ;
         endcase
      end
   end

   // Read data only during a read data phase; writes and idle return 0.
   always_comb begin
      HRDATA = '0;
      if (rd_pend_q) begin
         case (addr_q)
            REG_DATA:       HRDATA = 32'(data_q);
            REG_DP_MASK:    HRDATA = 32'(dp_mask_q);
            REG_BLANK_MASK: HRDATA = 32'(blank_mask_q);
            REG_BLINK_MASK: HRDATA = 32'(blink_mask_q);
            REG_PRESCALE:   HRDATA = 32'(prescale_q);
            REG_BLINK_DIV:  HRDATA = 32'(blink_div_q);
            REG_CTRL:       HRDATA = 32'(ctrl_q);
            default:        HRDATA = '0;
         endcase
      end
   end

   // ---------------- Scan: dwell, index, frame, blink ----------------
   // PRESCALE=0 behaves as 1 (advance every cycle).
   assign dwell_last = (prescale_q == '0) ? '0 : prescale_q - PRESCALE_W'(1);
   assign idx_last   = (idx_q == IW'(NUM_DIGITS - 1));

   always_ff @(posedge HCLK) begin
      if (HRESET || !enable) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         frame_q     <= '0;
         blink_off_q <= 1'b0;
      end else begin
         // A PRESCALE write restarts the slot of the current digit.
         if (wr_prescale) begin
            cnt_q <= '0;
         end else if (cnt_q == dwell_last) begin
            cnt_q <= '0;
            idx_q <= idx_last ? '0 : idx_q + IW'(1);
            if (idx_last) begin
               if (frame_q == blink_div_q - 8'd1) begin
                  frame_q     <= '0;
                  blink_off_q <= ~blink_off_q;
               end else begin
                  frame_q <= frame_q + 8'd1;
               end
            end
         end else begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
         end
         // BLINK_DIV=0 parks the blink phase at "on".
         if (blink_div_q == '0) begin
            frame_q     <= '0;
            blink_off_q <= 1'b0;
         end
      end
   end

   // ---------------- Digit composition ----------------
   // Walk from the top digit down; a digit is leading-zero blanked while
   // every nibble from it upward is zero and carries no decimal point.
   always_comb begin
      lzb_blank = '0;
      lz_run    = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz_run       = lz_run && (data_q[4*i +: 4] == 4'h0) && !dp_mask_q[i];
         lzb_blank[i] = ctrl_q[CTRL_LZB_BIT] && lz_run;
      end
   end

   assign nibble = data_q[{idx_q, 2'b00} +: 4];

   // Gating with blink_div_q makes BLINK_DIV=0 light the digit immediately.
   assign dark = blank_mask_q[idx_q]
              || (blink_mask_q[idx_q] && blink_off_q && (blink_div_q != '0))
              || lzb_blank[idx_q];

   seg7_decode u_dec (
      .value (nibble),
      .segs  (glyph)
   );

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         ndigit_q <= ~NUM_DIGITS'(1);
         seg_q    <= seg7_glyph(4'h0);
         dp_q     <= 1'b0;
      end else if (!enable) begin
         ndigit_q <= '1;
         seg_q    <= '0;
         dp_q     <= 1'b0;
      end else begin
         ndigit_q <= ~(NUM_DIGITS'(1) << idx_q);
         seg_q    <= dark ? 7'h00 : glyph;
         dp_q     <= !dark && dp_mask_q[idx_q];
      end
   end

   assign nDigit = ndigit_q;
   assign DP     = dp_q;
   assign SegA   = seg_q[0];
   assign SegB   = seg_q[1];
   assign SegC   = seg_q[2];
   assign SegD   = seg_q[3];
   assign SegE   = seg_q[4];
   assign SegF   = seg_q[5];
   assign SegG   = seg_q[6];

endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;

   logic        HCLK, HRESET;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic        HWRITE, HREADY, HSEL, HREADYOUT;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic        SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP;
   logic [3:0]  nDigit;

   seg_display_ctrl #(.NUM_DIGITS(4), .PRESCALE_W(16)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA),
      .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HSIZE(HSIZE),
      .HTRANS(HTRANS), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
      .SegA(SegA), .SegB(SegB), .SegC(SegC), .SegD(SegD), .SegE(SegE),
      .SegF(SegF), .SegG(SegG), .DP(DP), .nDigit(nDigit)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] glyph_tbl [16];

   // ---------------- behavioural model ----------------
   logic [15:0] m_data;
   logic [3:0]  m_dp, m_blank, m_blink;
   int          m_presc, m_bdiv;
   logic [1:0]  m_ctrl;
   int          m_dwell, m_idx, m_frames;
   bit          m_wr, m_rd;
   int          m_addr;
   logic [3:0]  e_ndig;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [31:0] e_rdata;

   function automatic bit m_dark(int i);
      bit lzb, blink_off;
      blink_off = (m_bdiv != 0) && (((m_frames / m_bdiv) % 2) == 1);
      lzb = m_ctrl[1] && (i > 0) && ((m_data >> (4*i)) == 16'd0) && ((m_dp >> i) == 4'd0);
      return m_blank[i] || (m_blink[i] && blink_off) || lzb;
   endfunction

   function automatic logic [31:0] m_reg(int a);
      case (a)
         0: return {16'd0, m_data};
         1: return {28'd0, m_dp};
         2: return {28'd0, m_blank};
         3: return {28'd0, m_blink};
         4: return 32'(m_presc);
         5: return 32'(m_bdiv);
         6: return {30'd0, m_ctrl};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step(bit rst, bit ap, bit hw, int off, logic [31:0] wd);
      bit dark;
      int dwell_len;
      if (rst) begin
         m_data = 0; m_dp = 0; m_blank = 0; m_blink = 0;
         m_presc = 1; m_bdiv = 0; m_ctrl = 2'b01;
         m_dwell = 0; m_idx = 0; m_frames = 0;
         m_wr = 0; m_rd = 0; m_addr = 0;
         e_ndig = 4'b1110; e_seg = 7'h3F; e_dp = 1'b0; e_rdata = 32'd0;
         return;
      end
      // outputs register what the state showed before this edge
      if (!m_ctrl[0]) begin
         e_ndig = 4'hF; e_seg = 7'h00; e_dp = 1'b0;
      end else begin
         dark   = m_dark(m_idx);
         e_ndig = ~(4'b0001 << m_idx);
         e_seg  = dark ? 7'h00 : glyph_tbl[(m_data >> (4*m_idx)) & 16'hF];
         e_dp   = !dark && m_dp[m_idx];
      end
      // scan progress, driven by the pre-edge register contents
      dwell_len = (m_presc == 0) ? 1 : m_presc;
      if (!m_ctrl[0]) begin
         m_dwell = 0; m_idx = 0; m_frames = 0;
      end else if (m_wr && m_addr == 4) begin
         m_dwell = 0;
      end else begin
         m_dwell++;
         if (m_dwell >= dwell_len) begin
            m_dwell = 0;
            m_idx = (m_idx + 1) % 4;
            if (m_idx == 0) m_frames++;
         end
      end
      if (m_bdiv == 0) m_frames = 0;
      // data phase write lands at this edge
      if (m_wr) begin
         case (m_addr)
            0: m_data  = wd[15:0];
            1: m_dp    = wd[3:0];
            2: m_blank = wd[3:0];
            3: m_blink = wd[3:0];
            4: m_presc = int'(wd[15:0]);
            5: m_bdiv  = int'(wd[7:0]);
            6: m_ctrl  = wd[1:0];
            default: ;
         endcase
      end
      m_wr = ap && hw;
      m_rd = ap && !hw;
      if (ap) m_addr = off;
      e_rdata = m_rd ? m_reg(m_addr) : 32'd0;
   endtask

   // ---------------- per-cycle compare ----------------
   task automatic step();
      bit rst, ap, hw;
      int off;
      logic [31:0] wd;
      rst = HRESET; ap = HSEL && HREADY && HTRANS[1]; hw = HWRITE;
      off = int'(HADDR[4:2]); wd = HWDATA;
      @(posedge HCLK);
      model_step(rst, ap, hw, off, wd);
      #1;
      n_cmp++;
      if ({nDigit, SegG, SegF, SegE, SegD, SegC, SegB, SegA, DP} !== {e_ndig, e_seg, e_dp}) begin
         n_bad++;
         $display("FAIL outputs t=%0t got nDigit=%b seg=%h dp=%b want nDigit=%b seg=%h dp=%b",
                  $time, nDigit, {SegG, SegF, SegE, SegD, SegC, SegB, SegA}, DP, e_ndig, e_seg, e_dp);
      end
      n_cmp++;
      if (HRDATA !== e_rdata) begin
         n_bad++;
         $display("FAIL hrdata t=%0t got %h want %h", $time, HRDATA, e_rdata);
      end
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // ---------------- bus tasks ----------------
   task automatic bus_idle();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1;
      HADDR = $urandom;
   endtask

   task automatic wr(int off, logic [31:0] d);
      logic [31:0] a;
      a = $urandom; a[4:2] = off[2:0];
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HREADY = 1'b1; HADDR = a;
      step();
      bus_idle(); HWDATA = d;
      step();
      HWDATA = $urandom;
   endtask

   task automatic rd(int off, output logic [31:0] v);
      logic [31:0] a;
      a = $urandom; a[4:2] = off[2:0];
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HREADY = 1'b1; HADDR = a;
      step();
      v = HRDATA;
      bus_idle();
   endtask

   task automatic wait_nd(logic [3:0] t, bit want_eq);
      int n;
      n = 0;
      while ((nDigit === t) != want_eq) begin
         step();
         n++;
         if (n > 100) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_ndigit timeout waiting for %b eq=%0d", t, want_eq);
            break;
         end
      end
   endtask

   logic [3:0] seq_nd [4];
   logic [31:0] v;
   int run, lit;
   logic [3:0] d0;
   logic [6:0] seg_now;
   assign seg_now = {SegG, SegF, SegE, SegD, SegC, SegB, SegA};

   initial begin
      glyph_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      seq_nd = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      HRESET = 1'b1; HWDATA = 32'd0; HSIZE = 3'b010;
      bus_idle();
      step(); step();
      chk("reset_ndigit", 32'(nDigit), 32'h0000000E);
      chk("reset_seg", 32'(seg_now), 32'h0000003F);
      chk("reset_hreadyout", 32'(HREADYOUT), 32'h1);
      HRESET = 1'b0;

      // scan at PRESCALE=1, all digits "0"
      for (int k = 0; k < 8; k++) begin
         step();
         chk("scan_ndigit", 32'(nDigit), 32'(seq_nd[k % 4]));
         chk("scan_seg0", 32'(seg_now), 32'h3F);
      end

      // DATA=0x12AF, PRESCALE=3
      wr(0, 32'hDEAD12AF);
      wr(4, 32'h00000003);
      wait_nd(4'b1110, 1'b0);
      wait_nd(4'b1110, 1'b1);
      chk("d0_glyph_F", 32'(seg_now), 32'h71);
      run = 1;
      step();
      while (nDigit === 4'b1110 && run < 20) begin run++; step(); end
      chk("dwell_3", 32'(run), 32'd3);
      wait_nd(4'b0111, 1'b1);
      chk("d3_glyph_1", 32'(seg_now), 32'h06);
      rd(0, v);
      chk("read_data", v, 32'h000012AF);
      rd(7, v);
      chk("read_off7", v, 32'h0);

      // LZB with decimal point
      wr(4, 32'd1);
      wr(0, 32'h0005);
      wr(1, 32'h2);
      wr(6, 32'h3);
      for (int k = 0; k < 8; k++) begin
         step();
         case (nDigit)
            4'b1110: chk("lzb_d0", 32'({seg_now, DP}), 32'({7'h6D, 1'b0}));
            4'b1101: chk("lzb_d1", 32'({seg_now, DP}), 32'({7'h3F, 1'b1}));
            4'b1011: chk("lzb_d2", 32'({seg_now, DP}), 32'h0);
            default: chk("lzb_d3", 32'({nDigit, seg_now, DP}), 32'({4'b0111, 8'h00}));
         endcase
      end

      // blinking digit 0, BLINK_DIV=2
      wr(6, 32'h1);
      wr(0, 32'h0008);
      wr(1, 32'h0);
      wr(3, 32'h1);
      wr(5, 32'h2);
      lit = 0;
      for (int k = 0; k < 32; k++) begin
         step();
         if (nDigit === 4'b1110 && seg_now !== 7'h00) lit++;
      end
      chk("blink_lit_half", 32'(lit), 32'd4);
      wr(5, 32'h0);
      lit = 0;
      for (int k = 0; k < 32; k++) begin
         step();
         if (nDigit === 4'b1110 && seg_now !== 7'h00) lit++;
      end
      chk("blink_div0_lit", 32'(lit), 32'd8);

      // PRESCALE rewrite mid-dwell, then disable / re-enable
      wr(4, 32'd3);
      step();
      wr(4, 32'd5);
      d0 = nDigit;
      run = 0;
      for (int k = 0; k < 5; k++) begin step(); if (nDigit === d0) run++; end
      chk("presc_restart_hold", 32'(run), 32'd5);
      step();
      chk("presc_restart_adv", 32'(nDigit === d0), 32'd0);
      wr(6, 32'h0);
      step();
      chk("disable_ndigit", 32'({nDigit, seg_now, DP}), 32'({4'hF, 8'h00}));
      wr(6, 32'h1);
      step();
      chk("reenable_d0", 32'(nDigit), 32'h0000000E);

      // reset in the data phase of a DATA write
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
      step();
      bus_idle(); HWDATA = 32'h0000FFFF; HRESET = 1'b1;
      step(); step();
      HRESET = 1'b0;
      rd(0, v);
      chk("reset_aborts_write", v, 32'h0);

      // randomized traffic against the model
      for (int op = 0; op < 400; op++) begin
         int r;
         r = $urandom_range(0, 9);
         v = $urandom;
         case (r)
            0, 1: wr(0, v);
            2: wr($urandom_range(1, 3), v);
            3: begin v[0] = ($urandom_range(0, 4) != 0); wr(6, v); end
            4: begin v[15:0] = 16'($urandom_range(0, 4)); wr(4, v); end
            5: begin
               if (m_bdiv == 0 || !m_ctrl[0]) v[7:0] = 8'($urandom_range(0, 3));
               else v[7:0] = 8'h00;
               wr(5, v);
            end
            6, 7: rd($urandom_range(0, 7), v);
            8: begin
               for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                  case ($urandom_range(0, 2))
                     0: begin HSEL = 1'b1; HTRANS = 2'b01; HREADY = 1'b1; end
                     1: begin HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b0; end
                     default: begin HSEL = 1'b0; HTRANS = 2'b10; HREADY = 1'b1; end
                  endcase
                  HWRITE = 1'($urandom); HADDR = $urandom; HWDATA = $urandom;
                  step();
               end
               bus_idle();
            end
            default: wr(7, v);
         endcase
         if ($urandom_range(0, 3) == 0) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
